// File: rtl/shift_ctrl.sv
// Shifter sequencing controller: decodes a shift request into the amount/data select,
// memory read, load/shift command and register write strobe over a short FSM.
module shift_ctrl #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] funct,
    input  logic       flush,
    output logic [1:0] Shift_Amt,
    output logic       Shift_Src,
    output logic [2:0] Shift_Ctrl,
    output logic       Mem_Read,
    output logic       Reg_Write_Shift,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned FUNCT_W = 3;
    localparam int unsigned AMT_W   = 2;
    localparam int unsigned CTRL_W  = 3;

    localparam logic [FUNCT_W-1:0] F_SLL  = 3'b000;
    localparam logic [FUNCT_W-1:0] F_SRL  = 3'b001;
    localparam logic [FUNCT_W-1:0] F_SRA  = 3'b010;
    localparam logic [FUNCT_W-1:0] F_SLLV = 3'b011;
    localparam logic [FUNCT_W-1:0] F_SRLV = 3'b100;
    localparam logic [FUNCT_W-1:0] F_SRAV = 3'b101;
    localparam logic [FUNCT_W-1:0] F_SLLM = 3'b110;
    localparam logic [FUNCT_W-1:0] F_RSVD = 3'b111;

    localparam logic [AMT_W-1:0] AMT_REGB = 2'b00;
    localparam logic [AMT_W-1:0] AMT_IMM  = 2'b01;
    localparam logic [AMT_W-1:0] AMT_MEM  = 2'b10;

    localparam logic [CTRL_W-1:0] C_HOLD = 3'b000;
    localparam logic [CTRL_W-1:0] C_LOAD = 3'b001;
    localparam logic [CTRL_W-1:0] C_SLL  = 3'b010;
    localparam logic [CTRL_W-1:0] C_SRL  = 3'b011;
    localparam logic [CTRL_W-1:0] C_SRA  = 3'b100;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MEMRD = 3'd1,
        LOAD  = 3'd2,
        SHIFT = 3'd3,
        WRITE = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [FUNCT_W-1:0] funct_q, funct_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [AMT_W-1:0]  shift_amt_q, shift_amt_d;
    logic              shift_src_q, shift_src_d;
    logic [CTRL_W-1:0] shift_ctrl_q, shift_ctrl_d;
    logic              mem_read_q, mem_read_d;
    logic              reg_write_q, reg_write_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            funct_q      <= F_SLL;
            cnt_q        <= '0;
            shift_amt_q  <= AMT_REGB;
            shift_src_q  <= 1'b1;
            shift_ctrl_q <= C_HOLD;
            mem_read_q   <= 1'b0;
            reg_write_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            funct_q      <= funct_d;
            cnt_q        <= cnt_d;
            shift_amt_q  <= shift_amt_d;
            shift_src_q  <= shift_src_d;
            shift_ctrl_q <= shift_ctrl_d;
            mem_read_q   <= mem_read_d;
            reg_write_q  <= reg_write_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    // Next state; flush beats every other transition, and a flushed start in IDLE is dropped.
    always_comb begin
        state_d = state_q;
        funct_d = funct_q;
        cnt_d   = cnt_q;
        if (flush && (state_q != IDLE)) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && !flush) begin
                        funct_d = funct;
                        if (funct == F_RSVD) begin
                            state_d = ERR;
                        end else if (funct == F_SLLM) begin
                            state_d = MEMRD;
                            cnt_d   = CNT_W'(MEM_WAIT - 1);
                        end else begin
                            state_d = LOAD;
                        end
                    end
                end
                MEMRD: begin
                    if (cnt_q == '0) begin
                        state_d = LOAD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                LOAD:    state_d = SHIFT;
                SHIFT:   state_d = WRITE;
                WRITE:   state_d = IDLE;
                ERR:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state/funct, so they track the state register exactly.
    always_comb begin
        shift_amt_d  = AMT_REGB;
        shift_src_d  = 1'b1;
        shift_ctrl_d = C_HOLD;
        mem_read_d   = 1'b0;
        reg_write_d  = 1'b0;
        busy_d       = (state_d != IDLE);
        done_d       = 1'b0;
        error_d      = 1'b0;

        if ((state_d != IDLE) && (state_d != ERR)) begin
            unique case (funct_d)
                F_SLL, F_SRL, F_SRA: shift_amt_d = AMT_IMM;
                F_SLLM:              shift_amt_d = AMT_MEM;
                default:             shift_amt_d = AMT_REGB;
            endcase
            shift_src_d = !((funct_d == F_SLLV) || (funct_d == F_SRLV) || (funct_d == F_SRAV));
        end

        unique case (state_d)
            MEMRD: mem_read_d   = 1'b1;
            LOAD:  shift_ctrl_d = C_LOAD;
            SHIFT: begin
                unique case (funct_d)
                    F_SLL, F_SLLV, F_SLLM: shift_ctrl_d = C_SLL;
                    F_SRL, F_SRLV:         shift_ctrl_d = C_SRL;
                    default:               shift_ctrl_d = C_SRA;
                endcase
            end
            WRITE: begin
                reg_write_d = 1'b1;
                done_d      = 1'b1;
            end
            ERR:     error_d = 1'b1;
            default: ;
        endcase
    end

    assign Shift_Amt       = shift_amt_q;
    assign Shift_Src       = shift_src_q;
    assign Shift_Ctrl      = shift_ctrl_q;
    assign Mem_Read        = mem_read_q;
    assign Reg_Write_Shift = reg_write_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;

endmodule
